// File: rtl/stream_light_multi.sv
// stream_light_multi
//   Parametrised running-light driver for the board LED bank. A prescaler
//   turns CLK_in into step ticks (period DIV<<Speed cycles). On each tick a
//   small mode machine advances the LED pattern: rotate, bounce, fill or blink.
//
// Ports
//   CLK_in   in   1      board clock, rising edge
//   Reset_n  in   1      asynchronous active-low reset
//   Stop     in   1      level, freezes all state while high
//   Reverse  in   1      direction select for ROTATE and FILL
//   Mode     in   2      00 ROTATE, 01 BOUNCE, 10 FILL, 11 BLINK
//   Speed    in   2      step period = DIV<<Speed cycles
//   LED      out  WIDTH  registered pattern
//   Step     out  1      one-cycle pulse in the cycle LED shows a new step
//   Dir      out  1      0 = toward MSB, 1 = toward LSB (registered)
//
// mode_q        | meaning
// --------------+-----------------------------------------------------------
// MODE_ROTATE   | single lit LED rotates, direction from Reverse
// MODE_BOUNCE   | single lit LED runs to an end, turns around (Dir tracks it)
// MODE_FILL     | LEDs fill from one end, restart once all are lit
// MODE_BLINK    | whole bank toggles between all-on and all-off

module stream_light_multi #(
   parameter int WIDTH = 16,
   parameter int DIV   = 10000000,
   parameter int CNT_W = 32
) (
   input  logic             CLK_in,
   input  logic             Reset_n,
   input  logic             Stop,
   input  logic             Reverse,
   input  logic [1:0]       Mode,
   input  logic [1:0]       Speed,
   output logic [WIDTH-1:0] LED,
   output logic             Step,
   output logic             Dir
);

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'b00,
      MODE_BOUNCE = 2'b01,
      MODE_FILL   = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] LED_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] DIV_W   = CNT_W'(DIV);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mode_e            mode_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] limit_m1;
   logic             tick;
   logic             mode_chg;

   // Greater-or-equal rather than equality: lowering Speed while cnt is
   // already past the new limit yields an immediate tick instead of a wrap.
   assign limit_m1 = (DIV_W << Speed) - CNT_ONE;
   assign tick     = (cnt >= limit_m1);
   assign mode_chg = (Mode != mode_q);

   function automatic logic [WIDTH-1:0] init_pat(input logic [1:0] m,
                                                 input logic       rev);
      logic [WIDTH-1:0] p;
      p = LED_LSB;
      case (m)
         2'b00, 2'b10: p = rev ? LED_MSB : LED_LSB;
         2'b01:        p = LED_LSB;
         default:      p = '1;
      endcase
      return p;
   endfunction

   always_ff @(posedge CLK_in or negedge Reset_n) begin
      if (!Reset_n) begin
         LED    <= LED_LSB;
         cnt    <= '0;
         Dir    <= 1'b0;
         Step   <= 1'b0;
         mode_q <= MODE_ROTATE;
      end else if (Stop) begin
         Step <= 1'b0;
      end else if (mode_chg) begin
         mode_q <= mode_e'(Mode);
         cnt    <= '0;
         Step   <= 1'b0;
         LED    <= init_pat(Mode, Reverse);
         // ROTATE/FILL pick up their direction at the first tick.
         if (Mode == MODE_BOUNCE || Mode == MODE_BLINK)
            Dir <= 1'b0;
      end else if (tick) begin
         cnt  <= '0;
         Step <= 1'b1;
         case (mode_q)
            MODE_ROTATE: begin
               Dir <= Reverse;
               if (LED == '0)
                  LED <= init_pat(mode_q, Reverse);
               else if (Reverse)
                  LED <= {LED[0], LED[WIDTH-1:1]};
               else
                  LED <= {LED[WIDTH-2:0], LED[WIDTH-1]};
            end
            MODE_BOUNCE: begin
               if (LED == '0) begin
                  LED <= LED_LSB;
                  Dir <= 1'b0;
               end else if (!Dir && LED[WIDTH-1]) begin
                  Dir <= 1'b1;
                  LED <= LED >> 1;
               end else if (Dir && LED[0]) begin
                  Dir <= 1'b0;
                  LED <= LED << 1;
               end else if (Dir) begin
                  LED <= LED >> 1;
               end else begin
                  LED <= LED << 1;
               end
            end
            MODE_FILL: begin
               Dir <= Reverse;
               // Both the empty (recovery) and full cases restart the fill.
               if (LED == '0 || &LED)
                  LED <= init_pat(mode_q, Reverse);
               else if (Reverse)
                  LED <= {1'b1, LED[WIDTH-1:1]};
               else
                  LED <= {LED[WIDTH-2:0], 1'b1};
            end
            default: begin
               Dir <= 1'b0;
               LED <= ~LED;
            end
         endcase
      end else begin
         cnt  <= cnt + CNT_ONE;
         Step <= 1'b0;
      end
   end

endmodule
